// File: rtl/axi_lite_slave_regs_if.sv
// AXI-Lite bus bundle between a master and the register block.
// Carries the five AXI-Lite channels; clock and reset stay outside.
interface axi_lite_slave_regs_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite register block: NUM_REGS 32-bit control/status registers.
// One outstanding write and one outstanding read, handled independently.
module axi_lite_slave_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int unsigned NUM_REGS  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_lite_slave_regs_if.slave      s_axi_lite,
    output logic [NUM_REGS*32-1:0]    regs_o,
    output logic [NUM_REGS-1:0]       reg_wr_pulse_o
);
    localparam int unsigned IW   = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_RESP} rstate_e;

    wstate_e                     wstate_q, wstate_d;
    rstate_e                     rstate_q, rstate_d;
    logic                        aw_got_q, aw_got_d;
    logic                        w_got_q, w_got_d;
    logic [31:0]                 awaddr_q, awaddr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [3:0]                  wstrb_q, wstrb_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [NUM_REGS-1:0][31:0]   regs_q, regs_d;
    logic [NUM_REGS-1:0]         pulse_q, pulse_d;

    logic [31:0]                 aw_eff;
    logic [31:0]                 w_eff;
    logic [3:0]                  strb_eff;
    logic [31:0]                 woff;
    logic                        whit;
    logic [IW-1:0]               widx;
    logic [31:0]                 roff;
    logic                        rhit;
    logic [IW-1:0]               ridx;

    assign regs_o         = regs_q;
    assign reg_wr_pulse_o = pulse_q;
    assign s_axi_lite.bresp = bresp_q;
    assign s_axi_lite.rdata = rdata_q;
    assign s_axi_lite.rresp = rresp_q;

    // Write path: collect AW and W in any order, commit once both are held.
    always_comb begin
        wstate_d = wstate_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        regs_d   = regs_q;
        pulse_d  = '0;
        s_axi_lite.awready = 1'b0;
        s_axi_lite.wready  = 1'b0;
        s_axi_lite.bvalid  = 1'b0;

        aw_eff   = aw_got_q ? awaddr_q : s_axi_lite.awaddr;
        w_eff    = w_got_q ? wdata_q : s_axi_lite.wdata;
        strb_eff = w_got_q ? wstrb_q : s_axi_lite.wstrb;
        woff     = aw_eff - BASE_ADDR;
        whit     = woff < SPAN;
        widx     = woff[2 +: IW];

        unique case (wstate_q)
            W_IDLE: begin
                s_axi_lite.awready = !aw_got_q;
                s_axi_lite.wready  = !w_got_q;
                if (!aw_got_q && s_axi_lite.awvalid) begin
                    aw_got_d = 1'b1;
                    awaddr_d = s_axi_lite.awaddr;
                end
                if (!w_got_q && s_axi_lite.wvalid) begin
                    w_got_d = 1'b1;
                    wdata_d = s_axi_lite.wdata;
                    wstrb_d = s_axi_lite.wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    if (whit) begin
                        for (int b = 0; b < 4; b++) begin
                            if (strb_eff[b]) begin
                                regs_d[widx][8*b +: 8] = w_eff[8*b +: 8];
                            end
                        end
                        pulse_d[widx] = 1'b1;
                    end
                    bresp_d  = whit ? OKAY : SLVERR;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_lite.bvalid = 1'b1;
                if (s_axi_lite.bready) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: ;
        endcase
    end

    // Read path: sample the register file on AR, hold the beat until taken.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        s_axi_lite.arready = 1'b0;
        s_axi_lite.rvalid  = 1'b0;

        roff = s_axi_lite.araddr - BASE_ADDR;
        rhit = roff < SPAN;
        ridx = roff[2 +: IW];

        unique case (rstate_q)
            R_IDLE: begin
                s_axi_lite.arready = 1'b1;
                if (s_axi_lite.arvalid) begin
                    rdata_d  = rhit ? regs_q[ridx] : 32'h0;
                    rresp_d  = rhit ? OKAY : SLVERR;
                    rstate_d = R_RESP;
                end
            end
            R_RESP: begin
                s_axi_lite.rvalid = 1'b1;
                if (s_axi_lite.rready) begin
                    rstate_d = R_IDLE;
                end
            end
            default: ;
        endcase
    end

    // State and register file update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            regs_q   <= '0;
            pulse_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            regs_q   <= regs_d;
            pulse_q  <= pulse_d;
        end
    end
endmodule
